// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with a retired-instruction counter.
// Define ILLEGAL_TRAP_EN to trap illegal opcodes into HALT with a sticky illegal_op flag.
module multi_cycle_control_unit #(
  parameter int OPCODE_WIDTH     = 4,
  parameter int RETIRE_CNT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [OPCODE_WIDTH-1:0]     opcode,
  input  logic                        zero_flag,
  input  logic                        mem_ready,
  output logic                        pc_write,
  output logic                        ir_write,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic                        iord,
  output logic                        reg_write,
  output logic                        mem_to_reg,
  output logic                        reg_dst,
  output logic                        alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [1:0]                  alu_op,
  output logic [1:0]                  pc_src,
  output logic                        halted,
  output logic                        illegal_op,
  output logic [2:0]                  state_out,
  output logic [RETIRE_CNT_WIDTH-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(15);

  state_t state;
  state_t next_state;
  logic   retire_inc;
  logic   op_legal;

  assign state_out = state;
  assign op_legal  = (opcode == OP_ADD) || (opcode == OP_ADDI) || (opcode == OP_LOAD) ||
                     (opcode == OP_STORE) || (opcode == OP_BEQ) || (opcode == OP_JMP);

`ifdef ILLEGAL_TRAP_EN
  logic trap;
  logic illegal_q;
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    halted     = 1'b0;
    retire_inc = 1'b0;
    next_state = state;
`ifdef ILLEGAL_TRAP_EN
    trap       = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch target while the opcode is being decoded
        alu_src_b = 2'b10;
        if (opcode == OP_HALT) begin
          next_state = S_HALT;
        end else if (op_legal) begin
          next_state = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          trap       = 1'b1;
          next_state = S_HALT;
`else
          retire_inc = 1'b1;
          next_state = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        next_state = S_FETCH;
        if (opcode == OP_ADD) begin
          alu_src_a  = 1'b1;
          alu_op     = 2'b10;
          next_state = S_WB;
        end else if (opcode == OP_ADDI || opcode == OP_LOAD || opcode == OP_STORE) begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          next_state = (opcode == OP_ADDI) ? S_WB : S_MEM;
        end else if (opcode == OP_BEQ) begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          pc_write  = zero_flag;
        end else if (opcode == OP_JMP) begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        retire_inc = (next_state == S_FETCH);
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = (opcode == OP_LOAD);
        mem_write = (opcode == OP_STORE);
        if (mem_ready) begin
          next_state = (opcode == OP_LOAD) ? S_WB : S_FETCH;
          retire_inc = (opcode != OP_LOAD);
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_ADD);
        mem_to_reg = (opcode == OP_LOAD);
        retire_inc = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_FETCH;
      retired_count <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q     <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (retire_inc) retired_count <= retired_count + RETIRE_CNT_WIDTH'(1);
`ifdef ILLEGAL_TRAP_EN
      if (trap) illegal_q <= 1'b1;
`endif
    end
  end

endmodule

// File: doc/multi_cycle_control_unit.md
MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 Parameter OPCODE_WIDTH, default 4, SHALL set the width of the opcode input.
REQ-002 Parameter RETIRE_CNT_WIDTH, default 16, SHALL set the width of the retired-instruction counter.
REQ-003 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 opcode  input  OPCODE_WIDTH  SHALL carry the opcode field from the instruction decoder.
REQ-006 zero_flag  input  1  SHALL carry the ALU result-equals-zero flag.
REQ-007 mem_ready  input  1  SHALL indicate memory read/write completes this cycle.
REQ-008 Outputs, each SHALL be 1 bit unless noted: pc_write, ir_write, mem_read, mem_write, iord (0=PC addr, 1=ALU addr), reg_write, mem_to_reg, reg_dst, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0], halted, illegal_op.
REQ-009 state_out  output  3  SHALL expose the current FSM state; retired_count  output  RETIRE_CNT_WIDTH  SHALL expose retired instructions.

Function
REQ-010 States and codes SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to FETCH next cycle.
REQ-011 Opcodes SHALL be ADD=0, ADDI=1, LOAD=2, STORE=3, BEQ=4, JMP=5, HALT=15; all others are illegal.
REQ-012 Control outputs SHALL be combinational from state and opcode only; any output not listed for a state SHALL be 0.
REQ-013 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00; when mem_ready=1, ir_write=1, pc_write=1, pc_src=00, next=DECODE; else hold FETCH with ir_write=pc_write=0.
REQ-014 DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target); next=EXEC for ADD/ADDI/LOAD/STORE/BEQ/JMP, HALT for HALT, illegal per REQ-025.
REQ-015 EXEC ADD: alu_src_a=1, alu_src_b=00, alu_op=10; next=WB.
REQ-016 EXEC ADDI/LOAD/STORE: alu_src_a=1, alu_src_b=10, alu_op=00; next=WB for ADDI, MEM for LOAD/STORE.
REQ-017 EXEC BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=zero_flag; next=FETCH.
REQ-018 EXEC JMP: pc_src=10, pc_write=1; next=FETCH.
REQ-019 MEM: iord=1; LOAD asserts mem_read, STORE asserts mem_write; held until mem_ready=1; then LOAD->WB, STORE->FETCH.
REQ-020 WB: reg_write=1; ADD reg_dst=1, mem_to_reg=0; ADDI reg_dst=0, mem_to_reg=0; LOAD reg_dst=0, mem_to_reg=1; next=FETCH.
REQ-021 Latency with mem_ready=1 throughout SHALL be BEQ/JMP 3, ADD/ADDI/STORE 4, LOAD 5 cycles; each mem_ready=0 cycle in FETCH/MEM adds one.
REQ-022 retired_count SHALL increment by 1 on every transition into FETCH from EXEC, MEM or WB, wrapping modulo 2^RETIRE_CNT_WIDTH.
REQ-023 HALT: halted=1, all other control outputs 0, state held until reset; retired_count frozen.
REQ-024 opcode SHALL only be sampled in DECODE, EXEC, MEM, WB (IR stable after FETCH).

Reset
REQ-025 Illegal opcode in DECODE without the macro of REQ-029 SHALL be a NOP: next=FETCH, retired_count increments.
REQ-026 reset=1 at a rising edge SHALL force state=FETCH, retired_count=0, illegal_op=0, regardless of current state, including mid-MEM wait or HALT.
REQ-027 After reset the outputs SHALL be the FETCH values: mem_read=1, alu_src_b=01, state_out=0, halted=0, all others 0.
REQ-028 A write in flight (MEM, STORE) when reset asserts SHALL be abandoned; mem_write SHALL be 0 the cycle after reset.

Configuration
REQ-029 Macro ILLEGAL_TRAP_EN defined: illegal opcode in DECODE SHALL go to HALT and set registered illegal_op=1 until reset.
REQ-030 Macro ILLEGAL_TRAP_EN undefined: REQ-025 applies and illegal_op SHALL be constant 0.

Verification
REQ-031 Reset, mem_ready=1, opcode=0 -> states 0,1,2,4,0; reg_write=1 only in WB with reg_dst=1; retired_count=1.
REQ-032 opcode=2, mem_ready low 2 cycles in MEM -> 0,1,2,3,3,3,4,0 (7 cycles); mem_to_reg=1 in WB.
REQ-033 opcode=4: zero_flag=1 -> pc_write=1, pc_src=01 in EXEC; zero_flag=0 -> pc_write=0; 3 cycles each.
REQ-034 opcode=15 -> halted=1 from cycle 3, held 20 cycles; reset -> state_out=0, retired_count=0.
REQ-035 opcode=7: without ILLEGAL_TRAP_EN -> back to FETCH, count+1; with it -> HALT, illegal_op=1.
REQ-036 Preload retired_count near max via 65535 ADDs (RETIRE_CNT_WIDTH=16) -> one more wraps to 0; reset during MEM wait -> FETCH next cycle.
